// File: rtl/dfa_ram_port_arbiter.sv
// ============================================================================
// Module   : dfa_ram_port_arbiter
// Brief    : Two-requester arbiter for the lookahead data RAM. Independent
//            round-robin write/read channels, read returns steered by a tag
//            pipeline. Optional build macro DFA_ARB_FIXED_PRIORITY_EN
//            selects fixed priority (m0 wins) on both channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfa_ram_port_arbiter #(
    parameter int ADDR_WIDTH   = 1,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    input  logic                  m0_write,
    input  logic                  m0_read,
    output logic                  m0_waitrequest,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    input  logic                  m1_write,
    input  logic                  m1_read,
    output logic                  m1_waitrequest,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0] ram_wr_address,
    output logic [DATA_WIDTH-1:0] ram_wr_writedata,
    output logic                  ram_wr_write,
    input  logic                  ram_wr_waitrequest,
    output logic [ADDR_WIDTH-1:0] ram_rd_address,
    input  logic [DATA_WIDTH-1:0] ram_rd_readdata
);

    localparam int LAST_STAGE = READ_LATENCY - 1;

    // Reset is folded into the gate so requesters see waitrequest while held in reset.
    logic gate;
    logic wr_req0, wr_req1, rd_req0, rd_req1;
    logic wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1, rd_gnt;

    assign gate    = ram_wr_waitrequest | ~reset_n;
    assign wr_req0 = m0_write & ~gate;
    assign wr_req1 = m1_write & ~gate;
    // A simultaneous write+read from one requester is treated as a write only.
    assign rd_req0 = m0_read & ~m0_write & ~gate;
    assign rd_req1 = m1_read & ~m1_write & ~gate;

`ifdef DFA_ARB_FIXED_PRIORITY_EN
    assign wr_gnt1 = wr_req1 & ~wr_req0;
    assign rd_gnt1 = rd_req1 & ~rd_req0;
`else
    // Pointer holds the id of the requester that has priority on the next contention.
    logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    assign wr_gnt1 = wr_req1 & (~wr_req0 | wr_ptr_q);
    assign rd_gnt1 = rd_req1 & (~rd_req0 | rd_ptr_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_gnt0)      wr_ptr_d = 1'b1;
        else if (wr_gnt1) wr_ptr_d = 1'b0;
        if (rd_gnt0)      rd_ptr_d = 1'b1;
        else if (rd_gnt1) rd_ptr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`endif

    assign wr_gnt0 = wr_req0 & ~wr_gnt1;
    assign rd_gnt0 = rd_req0 & ~rd_gnt1;
    assign rd_gnt  = rd_gnt0 | rd_gnt1;

    assign ram_wr_write     = wr_gnt0 | wr_gnt1;
    assign ram_wr_address   = wr_gnt1 ? m1_address   : m0_address;
    assign ram_wr_writedata = wr_gnt1 ? m1_writedata : m0_writedata;

    assign m0_waitrequest = m0_write ? ~wr_gnt0 : (m0_read & ~rd_gnt0);
    assign m1_waitrequest = m1_write ? ~wr_gnt1 : (m1_read & ~rd_gnt1);

    // Read address and tag pipeline state.
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0] tag_id_q,  tag_id_d;

    always_comb begin
        rd_addr_d = rd_addr_q;
        if (rd_gnt) rd_addr_d = rd_gnt1 ? m1_address : m0_address;
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = rd_gnt;
        tag_id_d[0]  = rd_gnt1;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_q <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign ram_rd_address = rd_gnt ? rd_addr_d : rd_addr_q;

    assign m0_readdata      = ram_rd_readdata;
    assign m1_readdata      = ram_rd_readdata;
    assign m0_readdatavalid = tag_vld_q[LAST_STAGE] & ~tag_id_q[LAST_STAGE];
    assign m1_readdatavalid = tag_vld_q[LAST_STAGE] &  tag_id_q[LAST_STAGE];

endmodule

`default_nettype wire

// File: tb/tb_dfa_ram_port_arbiter.sv
// ============================================================================
// Module   : tb_dfa_ram_port_arbiter
// Brief    : Directed self-checking bench for dfa_ram_port_arbiter with a
//            two-entry lookahead RAM model (registered read, write bypass).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dfa_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       m0_address, m1_address;
    logic [7:0] m0_writedata, m1_writedata;
    logic       m0_write, m0_read, m1_write, m1_read;
    logic       m0_waitrequest, m1_waitrequest;
    logic [7:0] m0_readdata, m1_readdata;
    logic       m0_readdatavalid, m1_readdatavalid;
    logic       ram_wr_address, ram_rd_address;
    logic [7:0] ram_wr_writedata;
    logic       ram_wr_write;
    logic       ram_wr_waitrequest;
    logic [7:0] ram_rd_readdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dfa_ram_port_arbiter #(
        .ADDR_WIDTH  (1),
        .DATA_WIDTH  (8),
        .READ_LATENCY(1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .m0_address        (m0_address),
        .m0_writedata      (m0_writedata),
        .m0_write          (m0_write),
        .m0_read           (m0_read),
        .m0_waitrequest    (m0_waitrequest),
        .m0_readdata       (m0_readdata),
        .m0_readdatavalid  (m0_readdatavalid),
        .m1_address        (m1_address),
        .m1_writedata      (m1_writedata),
        .m1_write          (m1_write),
        .m1_read           (m1_read),
        .m1_waitrequest    (m1_waitrequest),
        .m1_readdata       (m1_readdata),
        .m1_readdatavalid  (m1_readdatavalid),
        .ram_wr_address    (ram_wr_address),
        .ram_wr_writedata  (ram_wr_writedata),
        .ram_wr_write      (ram_wr_write),
        .ram_wr_waitrequest(ram_wr_waitrequest),
        .ram_rd_address    (ram_rd_address),
        .ram_rd_readdata   (ram_rd_readdata)
    );

    // Lookahead RAM: a same-cycle write to the read address is returned.
    logic [7:0] mem [2];
    always @(posedge clk) begin
        if (ram_wr_write) mem[ram_wr_address] <= ram_wr_writedata;
        ram_rd_readdata <= (ram_wr_write && ram_wr_address == ram_rd_address)
                           ? ram_wr_writedata : mem[ram_rd_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; ram_wr_waitrequest = 1'b0;
        m0_address = 1'b0; m0_writedata = 8'h00; m0_write = 1'b0; m0_read = 1'b0;
        m1_address = 1'b0; m1_writedata = 8'h00; m1_write = 1'b0; m1_read = 1'b0;
        mem[0] = 8'h00; mem[1] = 8'h00;

        // In reset: request stalled, no strobes
        cyc(); m0_write = 1'b1; #1;
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_wr", ram_wr_write, 0);
        check("rst_m0_rdv", m0_readdatavalid, 0);
        check("rst_m1_rdv", m1_readdatavalid, 0);

        // RAM busy for 3 cycles holds the write off
        for (int i = 0; i < 3; i++) begin
            cyc(); reset_n = 1'b1; ram_wr_waitrequest = 1'b1;
            m0_address = 1'b0; m0_writedata = 8'h33; #1;
            check("hold_m0_wait", m0_waitrequest, 1);
            check("hold_wr", ram_wr_write, 0);
        end
        cyc(); ram_wr_waitrequest = 1'b0; #1;
        check("hold_rel_m0_wait", m0_waitrequest, 0);
        check("hold_rel_wr", ram_wr_write, 1);
        check("hold_rel_data", ram_wr_writedata, 8'h33);

        // Single m1 write: preload addr1
        cyc(); m0_write = 1'b0; m1_write = 1'b1; m1_address = 1'b1; m1_writedata = 8'hA5; #1;
        check("m1_wr_wait", m1_waitrequest, 0);
        check("m1_wr_addr", ram_wr_address, 1);
        check("m1_wr_data", ram_wr_writedata, 8'hA5);

        // Write contention alternates m0, m1, m0, m1
        for (int i = 0; i < 4; i++) begin
            cyc();
            m0_write = 1'b1; m0_address = 1'b0; m0_writedata = 8'h11;
            m1_write = 1'b1; m1_address = 1'b0; m1_writedata = 8'h22; #1;
            check("cont_data", ram_wr_writedata, (i % 2 == 0) ? 8'h11 : 8'h22);
            check("cont_m0_wait", m0_waitrequest, (i % 2 == 1) ? 1 : 0);
            check("cont_m1_wait", m1_waitrequest, (i % 2 == 0) ? 1 : 0);
        end

        // Preload addr0 with 0x5A
        cyc(); m1_write = 1'b0; m0_writedata = 8'h5A; #1;
        check("pre_wr", ram_wr_write, 1);

        // Read steering
        cyc(); m0_write = 1'b0;
        m0_read = 1'b1; m0_address = 1'b0; m1_read = 1'b1; m1_address = 1'b1; #1;
        check("rd1_addr", ram_rd_address, 0);
        check("rd1_m0_wait", m0_waitrequest, 0);
        check("rd1_m1_wait", m1_waitrequest, 1);
        cyc(); #1;
        check("rd2_addr", ram_rd_address, 1);
        check("rd2_m1_wait", m1_waitrequest, 0);
        check("rd2_m0_rdv", m0_readdatavalid, 1);
        check("rd2_m0_data", m0_readdata, 8'h5A);
        check("rd2_m1_rdv", m1_readdatavalid, 0);
        cyc(); #1;
        check("rd3_m0_wait", m0_waitrequest, 0);
        check("rd3_m1_rdv", m1_readdatavalid, 1);
        check("rd3_m1_data", m1_readdata, 8'hA5);
        check("rd3_m0_rdv", m0_readdatavalid, 0);
        cyc(); m0_read = 1'b0; m1_read = 1'b0; #1;
        check("rd4_m0_rdv", m0_readdatavalid, 1);
        check("rd4_m0_data", m0_readdata, 8'h5A);
        check("rd4_m1_rdv", m1_readdatavalid, 0);

        // Parallel write and read to the same address
        cyc(); m0_write = 1'b1; m0_address = 1'b1; m0_writedata = 8'h3C;
        m1_read = 1'b1; m1_address = 1'b1; #1;
        check("par_m0_wait", m0_waitrequest, 0);
        check("par_m1_wait", m1_waitrequest, 0);
        cyc(); m0_write = 1'b0; m1_read = 1'b0; #1;
        check("par_m1_rdv", m1_readdatavalid, 1);
        check("par_m1_data", m1_readdata, 8'h3C);
        check("par_m0_rdv", m0_readdatavalid, 0);

        // Mid-flight reset discards the outstanding tag
        cyc(); m1_read = 1'b1; m1_address = 1'b1; #1;
        check("mf_m1_wait", m1_waitrequest, 0);
        @(negedge clk); reset_n = 1'b0; m1_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            check("mf_m1_rdv", m1_readdatavalid, 0);
        end
        reset_n = 1'b1;
        cyc(); m0_write = 1'b1; m0_address = 1'b0; m0_writedata = 8'h44;
        m1_write = 1'b1; m1_address = 1'b0; m1_writedata = 8'h55; #1;
        check("mf_m0_wait", m0_waitrequest, 0);
        check("mf_m1_wait", m1_waitrequest, 1);
        check("mf_data", ram_wr_writedata, 8'h44);

        // Write and read together: write only
        cyc(); m1_write = 1'b0; m0_write = 1'b1; m0_read = 1'b1;
        m0_address = 1'b0; m0_writedata = 8'h77; #1;
        check("ill_wr", ram_wr_write, 1);
        check("ill_data", ram_wr_writedata, 8'h77);
        check("ill_m0_wait", m0_waitrequest, 0);
        cyc(); m0_write = 1'b0; m0_read = 1'b0; #1;
        check("ill_m0_rdv1", m0_readdatavalid, 0);
        cyc(); #1;
        check("ill_m0_rdv2", m0_readdatavalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dfa_ram_port_arbiter.md
Name: dfa_ram_port_arbiter

Overview:
- Shares one lookahead data RAM (one write port, one read port, registered read data) between two requesters, m0 and m1.
- Write and read channels are arbitrated independently, each with its own round-robin pointer.
- Read returns are steered back to the issuing requester through a tag pipeline matched to the RAM read latency.
- Sits between the format-adapter control logic and the data RAM, and holds off all traffic while the RAM reports ram_wr_waitrequest.

Parameters:
ADDR_WIDTH, 1, RAM address width
DATA_WIDTH, 8, RAM data width
READ_LATENCY, 1, cycles from ram_rd_address presented to ram_rd_readdata valid (1 = registered RAM output); legal range 1-4

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_WIDTH  requester 0 address
m0_writedata  in  DATA_WIDTH  requester 0 write data
m0_write  in  1  requester 0 write request
m0_read  in  1  requester 0 read request
m0_waitrequest  out  1  requester 0 stall; the request is not accepted this cycle
m0_readdata  out  DATA_WIDTH  requester 0 read data
m0_readdatavalid  out  1  m0_readdata valid this cycle
m1_*  (same seven signals as m0_*, for requester 1)
ram_wr_address  out  ADDR_WIDTH  RAM write address
ram_wr_writedata  out  DATA_WIDTH  RAM write data
ram_wr_write  out  1  RAM write strobe
ram_wr_waitrequest  in  1  RAM busy (reset/clear in progress)
ram_rd_address  out  ADDR_WIDTH  RAM read address
ram_rd_readdata  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. In reset:
  - write and read round-robin pointers = 0, so requester 0 wins the first contention;
  - tag pipeline cleared;
  - ram_rd_address register = 0.
- Reset output values:
  - all readdatavalid = 0;
  - ram_wr_write = 0;
  - mN_waitrequest = 1 for any requester asserting write or read.
- Request encoding:
  - a requester asserts at most one of write and read per cycle;
  - if both are asserted, write is taken and read is ignored, and read is reissued by the requester when it is next deasserted from write.
- Hold rule: a stalled requester holds address, data and strobe until mN_waitrequest = 0.
- Gating: while ram_wr_waitrequest = 1:
  - no write or read is granted;
  - every requesting master sees waitrequest = 1;
  - ram_wr_write = 0;
  - no new tags enter the pipeline.
- Write channel (combinational grant):
  - single writer: that requester is granted;
  - both writing: the requester that did not win the previous write grant is granted.
  - Pointer updates to the winner on every write grant and holds when there is no grant.
  - ram_wr_write = granted; ram_wr_address and ram_wr_writedata mux from the winner (outputs are don't-care-stable when there is no grant: hold the m0 values).
- Read channel:
  - same round-robin rule, with a separate pointer;
  - ram_rd_address = winner's address, combinational, in the grant cycle;
  - with no grant it is driven from a register holding the last granted read address.
- Waitrequest: mN_waitrequest = (mN_write or mN_read) and not granted on the channel used. It is combinational and asserts only when a request is present.
- Tag pipeline:
  - depth READ_LATENCY; each stage holds {valid, id};
  - on a read grant, stage0 = {1, winner id}; otherwise stage0 = {0, x}.
  - At the last stage, if valid, mN_readdatavalid = 1 for id N, and readdata = ram_rd_readdata for that requester.
  - Both readdata outputs are driven with ram_rd_readdata at all times; only readdatavalid qualifies them.
- Throughput and latency:
  - one write plus one read per cycle, in parallel;
  - read latency to the requester = READ_LATENCY cycles after acceptance.
- Same-cycle write and read to the same address (either requester): the RAM lookahead returns the new data; the arbiter adds no ordering logic.
- Reset asserted mid-operation:
  - outstanding tags are discarded, so no readdatavalid is produced for reads in flight;
  - pointers return to 0.
- Starvation bound: a continuously requesting master is granted within 2 cycles once ram_wr_waitrequest = 0.

Optional Feature:
DFA_ARB_FIXED_PRIORITY_EN
- Defined: both channels use fixed priority, with m0 always winning contention. Round-robin pointers are removed, and m1 can starve.
- Undefined (default): round-robin as described under Behaviour.

Test Plan:
- Reset hold: ram_wr_waitrequest = 1 for 3 cycles, m0_write = 1 -> m0_waitrequest = 1 and ram_wr_write = 0 for those 3 cycles; the write is accepted in the first cycle after ram_wr_waitrequest = 0.
- Write contention: m0 and m1 write continuously (addr 0, data 0x11 and 0x22) -> grants alternate m0, m1, m0, m1; ram_wr_writedata sequence 0x11, 0x22, 0x11, 0x22.
- Read steering: m0 reads addr 0 (contains 0x5A) and m1 reads addr 1 (contains 0xA5) continuously -> m0_readdatavalid with 0x5A, then m1_readdatavalid with 0xA5, each READ_LATENCY cycles after its grant; never both valid in one cycle.
- Parallel channels: m0 writes 0x3C to addr 1 while m1 reads addr 1 in the same cycle -> neither waitrequest asserted; m1 receives 0x3C after READ_LATENCY cycles.
- Mid-flight reset: m1 read granted, reset_n low on the next cycle -> no m1_readdatavalid ever issued for that read; after release, both masters contending -> m0 wins first.
- Illegal encoding: m0_write = 1 and m0_read = 1 (data 0x77) -> one RAM write of 0x77 occurs, no read tag enters the pipeline, and no m0_readdatavalid is issued.
